mux2_sel_arbiter: RTL and testbench

Upstream control stage for the 2:1 data mux. Two valid/ready requesters compete for one downstream channel. The block arbitrates round-robin at packet granularity, drives the mux select `sel`, and forwards the winning requester's data, last and valid to the consumer. A grant is held until the packet's last beat has handshaked.

---
 rtl/mux2_sel_pkg.sv | 15 +
 rtl/mux2_skid.sv | 67 ++++++
 rtl/mux2_sel_arbiter.sv | 118 +++++++++++
 tb/tb_mux2_sel_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux2_sel_pkg.sv
// Shared types for the mux2_sel_arbiter control stage: FSM state encoding
// and a helper that maps a requester index to its lock state.
package mux2_sel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    function automatic state_t lock_state(input logic who);
        return who ? LOCK1 : LOCK0;
    endfunction

endpackage

// File: rtl/mux2_skid.sv
// Two-entry skid buffer: registered valid/data/last outputs with full
// throughput under arbitrary out_ready patterns. Used by mux2_sel_arbiter.
module mux2_skid #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    logic          head_vld_p1;
    logic          spare_vld_p1;
    logic [DW-1:0] head_data_p1;
    logic [DW-1:0] spare_data_p1;
    logic          head_last_p1;
    logic          spare_last_p1;
    logic          push;
    logic          pop;
    logic          advance;

    // The spare slot only fills when the head is stalled, so "not full" is
    // simply "spare empty"; this keeps in_ready off the out_ready path.
    assign in_ready = !spare_vld_p1;
    assign push     = in_valid && in_ready;
    assign pop      = head_vld_p1 && out_ready;
    assign advance  = pop || !head_vld_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_vld_p1  <= 1'b0;
            spare_vld_p1 <= 1'b0;
        end else if (advance) begin
            head_vld_p1  <= spare_vld_p1 || push;
            spare_vld_p1 <= 1'b0;
        end else if (push) begin
            spare_vld_p1 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            if (spare_vld_p1) begin
                head_data_p1 <= spare_data_p1;
                head_last_p1 <= spare_last_p1;
            end else if (push) begin
                head_data_p1 <= in_data;
                head_last_p1 <= in_last;
            end
        end else if (push) begin
            spare_data_p1 <= in_data;
            spare_last_p1 <= in_last;
        end
    end

    // Output stage: flops, forced to zero while empty.
    assign out_valid = head_vld_p1;
    assign out_data  = head_data_p1 & {DW{head_vld_p1}};
    assign out_last  = head_last_p1 & head_vld_p1;

endmodule

// File: rtl/mux2_sel_arbiter.sv
// Packet-granular round-robin arbiter for two valid/ready requesters driving
// the 2:1 data mux select. Optional output skid buffer: MUX_SEL_OUT_REG_EN.
module mux2_sel_arbiter
    import mux2_sel_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic          req0_last,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic          req1_last,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          out_valid,
    output logic          out_last,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          sel,
    output logic          busy
);

    state_t        state;
    state_t        state_next;
    logic          prio;
    logic          prio_next;
    logic          sel_next;
    logic          granted;
    logic [DW-1:0] mux_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          burst_end;

    assign granted = (state == LOCK0) || (state == LOCK1);

    // Per-bit 2:1 select; sel equals the granted index while locked.
    for (genvar i = 0; i < DW; i++) begin : g_bit_mux
        assign mux_data[i] = sel ? req1_data[i] : req0_data[i];
    end

    // A beat in the reset cycle is never acknowledged.
    assign in_valid  = granted && !rst && (sel ? req1_valid : req0_valid);
    assign in_last   = sel ? req1_last : req0_last;
    assign burst_end = in_valid && in_ready && in_last;

`ifdef MUX_SEL_OUT_REG_EN
    logic skid_ready;

    mux2_skid #(
        .DW(DW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (skid_ready),
        .in_data  (mux_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    assign in_ready = granted && !rst && skid_ready;
`else
    assign in_ready  = granted && !rst && out_ready;
    assign out_valid = in_valid;
    assign out_data  = granted ? mux_data : '0;
    assign out_last  = granted && in_last;
`endif

    assign req0_ready = in_ready && !sel;
    assign req1_ready = in_ready && sel;

    always_comb begin
        state_next = state;
        prio_next  = prio;
        sel_next   = sel;
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || !prio)) begin
                    state_next = lock_state(1'b0);
                    sel_next   = 1'b0;
                end else if (req1_valid) begin
                    state_next = lock_state(1'b1);
                    sel_next   = 1'b1;
                end
            end
            LOCK0, LOCK1: begin
                if (burst_end) begin
                    state_next = IDLE;
                    prio_next  = !sel;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control registers: sel and busy are flops so the mux never sees glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prio  <= 1'b0;
            sel   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            prio  <= prio_next;
            sel   <= sel_next;
            busy  <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_mux2_sel_arbiter.sv
// Directed bench for mux2_sel_arbiter: per-cycle comparison against a
// behavioural arbiter model, a beat scoreboard, and literal expectations.
module tb_mux2_sel_arbiter;

    localparam int DW = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_last, req0_ready;
    logic [DW-1:0] req0_data;
    logic          req1_valid, req1_last, req1_ready;
    logic [DW-1:0] req1_data;
    logic          out_valid, out_last, out_ready;
    logic [DW-1:0] out_data;
    logic          sel, busy;

    mux2_sel_arbiter #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_last (req0_last),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_last (req1_last),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int src;
        int data;
        int last;
    } beat_t;

    int    checks = 0;
    int    failures = 0;
    // Model: granted requester (-1 = none), priority pointer, expected sel.
    int    g = -1;
    int    mp = 0;
    int    msel = 0;
    int    hs0 = 0;
    int    hs1 = 0;
    int    cyc_n = 0;
    int    grant_log[$];
    int    grant_cycle[$];
    beat_t sbq[$];
    int    delivered = 0;
    int    first_acc = -1;
    int    first_out = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic a_v, input logic a_l, input logic a_d,
                         input logic b_v, input logic b_l, input logic b_d,
                         input logic o_r);
        req0_valid = a_v; req0_last = a_l; req0_data = a_d;
        req1_valid = b_v; req1_last = b_l; req1_data = b_d;
        out_ready  = o_r;
    endtask

    // One clock: compare at negedge, then advance the model over the edge.
    task automatic cyc();
        int    v[2];
        int    l[2];
        int    d[2];
        int    rd[2];
        int    ng, np, ns, hs;
        beat_t b;
        @(negedge clk);
        v[0] = int'(req0_valid); v[1] = int'(req1_valid);
        l[0] = int'(req0_last);  l[1] = int'(req1_last);
        d[0] = int'(req0_data);  d[1] = int'(req1_data);
        rd[0] = int'(req0_ready); rd[1] = int'(req1_ready);
        chk("sel", sel, msel);
        chk("busy", busy, (g >= 0) ? 1 : 0);
        if (g < 0) begin
            chk("idle_ready0", req0_ready, 0);
            chk("idle_ready1", req1_ready, 0);
`ifndef MUX_SEL_OUT_REG_EN
            chk("idle_out_valid", out_valid, 0);
            chk("idle_out_data", out_data, 0);
            chk("idle_out_last", out_last, 0);
`endif
        end else if (rst) begin
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
`ifndef MUX_SEL_OUT_REG_EN
            chk("rst_out_valid", out_valid, 0);
`endif
        end else begin
            chk("other_ready", (g == 0) ? req1_ready : req0_ready, 0);
`ifndef MUX_SEL_OUT_REG_EN
            chk("lock_out_valid", out_valid, v[g]);
            chk("lock_out_data", out_data, d[g]);
            chk("lock_out_last", out_last, l[g]);
            chk("lock_ready", (g == 0) ? req0_ready : req1_ready, int'(out_ready));
`endif
        end
`ifdef MUX_SEL_OUT_REG_EN
        hs = (g >= 0 && !rst && v[g] != 0 && rd[g] != 0) ? 1 : 0;
`else
        hs = (g >= 0 && !rst && v[g] != 0 && out_ready) ? 1 : 0;
`endif
        hs0 = (hs != 0 && g == 0) ? 1 : 0;
        hs1 = (hs != 0 && g == 1) ? 1 : 0;
        for (int s = 0; s < 2; s++) begin
            if (v[s] != 0 && rd[s] != 0) begin
                b.src = s; b.data = d[s]; b.last = l[s];
                sbq.push_back(b);
                if (first_acc < 0) first_acc = cyc_n;
            end
        end
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                b = sbq.pop_front();
                chk("sb_data", out_data, b.data);
                chk("sb_last", out_last, b.last);
                delivered++;
                if (first_out < 0) first_out = cyc_n;
            end
        end
        ng = g; np = mp; ns = msel;
        if (rst) begin
            ng = -1; np = 0; ns = 0;
        end else if (g < 0) begin
            if (v[0] != 0 && v[1] != 0) ng = mp;
            else if (v[0] != 0) ng = 0;
            else if (v[1] != 0) ng = 1;
            if (ng >= 0) begin
                ns = ng;
                grant_log.push_back(ng);
                grant_cycle.push_back(cyc_n);
            end
        end else if (hs != 0 && l[g] != 0) begin
            ng = -1;
            np = 1 - g;
        end
        @(posedge clk);
        #1;
        if (rst) sbq.delete();
        g = ng; mp = np; msel = ns;
        cyc_n++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1, k;
        // Reset held two cycles with both requesters valid.
        rst = 1'b1;
        drive(1, 1, 1, 1, 1, 0, 1);
        @(posedge clk);
        #1;
        cyc();
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_r0", req0_ready, 0);
        chk("rst_r1", req1_ready, 0);
        chk("rst_ov", out_valid, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_idle_busy", busy, 0);
        cyc();
        chk("first_grant_sel", sel, 0);
        chk("first_grant_busy", busy, 1);
        chk("first_grant_r0", req0_ready, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 1);
        cyc();

        // Single requester 1: 3-beat packet 1,0,1.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(0, 0, 0, 1, 0, 1, 1);
        #1;
        chk("t2_idle_r1", req1_ready, 0);
        cyc();
        chk("t2_sel", sel, 1);
        chk("t2_busy", busy, 1);
        chk("t2_r1", req1_ready, 1);
`ifndef MUX_SEL_OUT_REG_EN
        chk("t2_b1_data", out_data, 1);
        chk("t2_b1_last", out_last, 0);
`endif
        cyc();
        drive(0, 0, 0, 1, 0, 0, 1);
        #1;
`ifndef MUX_SEL_OUT_REG_EN
        chk("t2_b2_data", out_data, 0);
`endif
        cyc();
        drive(0, 0, 0, 1, 1, 1, 1);
        #1;
`ifndef MUX_SEL_OUT_REG_EN
        chk("t2_b3_data", out_data, 1);
        chk("t2_b3_last", out_last, 1);
`endif
        cyc();
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("t2_end_busy", busy, 0);
        chk("t2_model_prio", mp, 0);
        cyc();
        cyc();

        // Contention: both continuously valid with 2-beat packets.
        grant_log.delete();
        grant_cycle.delete();
        b0 = 0; b1 = 0;
        for (int i = 0; i < 13; i++) begin
            drive(1, logic'(b0 == 1), logic'(b0), 1, logic'(b1 == 1), logic'(b1 == 0), 1);
            cyc();
            if (hs0 != 0) b0 ^= 1;
            if (hs1 != 0) b1 ^= 1;
        end
        chk("t3_grants", grant_log.size() >= 4, 1);
        if (grant_log.size() >= 4) begin
            chk("t3_g0", grant_log[0], 0);
            chk("t3_g1", grant_log[1], 1);
            chk("t3_g2", grant_log[2], 0);
            chk("t3_g3", grant_log[3], 1);
            chk("t3_period01", grant_cycle[1] - grant_cycle[0], 3);
            chk("t3_period23", grant_cycle[3] - grant_cycle[2], 3);
        end

        // Backpressure: 4-beat packet on requester 0, out_ready low 3 cycles.
        drive(0, 0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        delivered = 0;
        drive(1, 0, 1, 0, 0, 0, 1);
        cyc();
        cyc();
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
`ifndef MUX_SEL_OUT_REG_EN
            chk("t4_stall_ready", req0_ready, 0);
            chk("t4_stall_data", out_data, 0);
            chk("t4_stall_valid", out_valid, 1);
`endif
            cyc();
        end
        drive(1, 0, 0, 0, 0, 0, 1);
        cyc();
        drive(1, 0, 1, 0, 0, 0, 1);
        cyc();
        drive(1, 1, 1, 0, 0, 0, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 1);
        cyc();
        cyc();
        chk("t4_delivered", delivered, 4);
        chk("t4_sb_empty", sbq.size(), 0);

        // Reset during beat 2 of a requester-1 packet.
        drive(0, 0, 0, 1, 0, 1, 1);
        cyc();
        cyc();
        drive(0, 0, 0, 1, 0, 0, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_r1", req1_ready, 0);
        chk("t5_rst_r0", req0_ready, 0);
        cyc();
        rst = 1'b0;
        drive(1, 1, 1, 1, 1, 1, 1);
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_sel", sel, 0);
        cyc();
        chk("t5_regrant_sel", sel, 0);
        chk("t5_regrant_busy", busy, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc();

        // 8-beat packet with out_ready alternating 1,0,1,0,...
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        delivered = 0;
        first_acc = -1;
        first_out = -1;
        k = 0;
        for (int i = 0; i < 60 && delivered < 8; i++) begin
            drive(logic'(k < 8), logic'(k == 7), logic'(k % 2), 0, 0, 0, logic'(i % 2 == 0));
            cyc();
            if (hs0 != 0) k++;
        end
        chk("t6_delivered", delivered, 8);
        chk("t6_sb_empty", sbq.size(), 0);
`ifdef MUX_SEL_OUT_REG_EN
        chk("t6_lag", first_out - first_acc, 1);
`else
        chk("t6_lag", first_out - first_acc, 0);
`endif
        drive(0, 0, 0, 0, 0, 0, 1);
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
